mem_access_ctrl: RTL

- M-stage memory access controller, directly downstream of the store byte-enable unit.
- Consumes the byte enables and lane-aligned store data from that unit, plus load requests. Runs a variable-latency req/ack transaction with the data memory and stalls the pipeline while the transaction is in flight.
- For loads, extracts and extends the addressed byte or halfword and holds the result registered for the W stage.

---
 rtl/mem_access_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// M-stage data memory access controller.
// Issues one req/ack transaction per access and extends load data.
module mem_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MemOpM,
  input  logic        MemReadM,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] fixed_Mem_data,
  input  logic [31:0] AddressM,
  input  logic        Req,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [3:0]         mem_we_q, mem_we_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [2:0]         op_q, op_d;
  logic [1:0]         off_q, off_d;
  logic               is_load_q, is_load_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ld_valid_q, ld_valid_d;
  logic [31:0]        ld_data_q, ld_data_d;
  logic               bus_err_q, bus_err_d;
  logic               access;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Select and extend the addressed byte/halfword of the read word.
  function automatic logic [31:0] extend(
    input logic [2:0]  op,
    input logic [1:0]  o,
    input logic [31:0] d
  );
    logic [15:0] h;
    logic [7:0]  b;
    h = o[1] ? d[31:16] : d[15:0];
    unique case (o)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    unique case (op)
      3'd1:    extend = {{16{h[15]}}, h};
      3'd2:    extend = {{24{b[7]}}, b};
      3'd3:    extend = {16'h0, h};
      3'd4:    extend = {24'h0, b};
      default: extend = d;
    endcase
  endfunction

  assign access = !Req && (MemReadM || |m_data_byteen);
  assign StallM = ((state_q == IDLE) && access) || (state_q == BUSY);

  // Next-state and registered-output logic of the transaction FSM.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    op_d        = op_q;
    off_d       = off_q;
    is_load_d   = is_load_q;
    cnt_d       = cnt_q;
    ld_valid_d  = 1'b0;
    ld_data_d   = ld_data_q;
    bus_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          mem_addr_d  = {AddressM[31:2], 2'b00};
          mem_we_d    = MemReadM ? 4'b0000 : m_data_byteen;
          mem_wdata_d = fixed_Mem_data;
          op_d        = MemOpM;
          off_d       = AddressM[1:0];
          is_load_d   = MemReadM;
          mem_req_d   = 1'b1;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (is_load_q) begin
            ld_data_d  = extend(op_q, off_q, mem_rdata);
            ld_valid_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= '0;
      mem_wdata_q <= '0;
      op_q        <= '0;
      off_q       <= '0;
      is_load_q   <= 1'b0;
      cnt_q       <= '0;
      ld_valid_q  <= 1'b0;
      ld_data_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      op_q        <= op_d;
      off_q       <= off_d;
      is_load_q   <= is_load_d;
      cnt_q       <= cnt_d;
      ld_valid_q  <= ld_valid_d;
      ld_data_q   <= ld_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign ld_valid  = ld_valid_q;
  assign ld_data   = ld_data_q;
  assign bus_err   = bus_err_q;

endmodule
